// File: rtl/cms_pix_28_fw_cfg_shifter.sv
// Serial configuration-chain engine for the CMS pix 28 test firmware: shifts a word-addressed
// TX buffer out on the DUT config pins and captures the returning chain into an RX buffer.
// Optional write-verify compare is built when CMS_PIX_28_FW_CFG_SHIFTER_CMP_EN is defined.
module cms_pix_28_fw_cfg_shifter #(
  parameter int CHAIN_LEN = 256,
  parameter int WORD_W    = 32,
  parameter int DIV_W     = 8,
  localparam int NUM_WORDS = CHAIN_LEN / WORD_W,
  localparam int AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int NW        = $clog2(CHAIN_LEN + 1)
) (
  input  logic              fw_clk_i,
  input  logic              fw_rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [NW-1:0]     cfg_nbits_i,
  input  logic [DIV_W-1:0]  cfg_half_div_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_len_o,
  output logic              cmp_mismatch_o,
  output logic              fw_config_clk_o,
  output logic              fw_config_in_o,
  output logic              fw_config_load_o,
  input  logic              fw_config_out_i
);

  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, CLK_HI, CLK_LO, LOAD, DONE} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [DIV_W-1:0]  halfDiv_q;
  logic [NW-1:0]     idx_q;
  logic [NW-1:0]     nbits_q;
  logic              tail_q;
  logic              busy_q;
  logic              done_q;
  logic              errLen_q;
  logic              cfgClk_q;
  logic              cfgIn_q;
  logic              cfgLoad_q;
  logic [WORD_W-1:0] rdData_q;
  logic [WORD_W-1:0] txMem [NUM_WORDS];
  logic [WORD_W-1:0] rxMem [NUM_WORDS];

  logic          tick;
  logic          lenOk;
  logic          wrAllowed;
  logic          captureEn;
  logic          txBit0;
  logic [AW-1:0] capWord;
  logic [BW-1:0] capBit;

  function automatic logic txBitAt(input logic [NW-1:0] k);
    logic [AW-1:0] w;
    logic [BW-1:0] b;
    w = AW'(k / NW'(WORD_W));
    b = BW'(k % NW'(WORD_W));
    return txMem[w][b];
  endfunction

  assign tick      = (cnt_q == halfDiv_q);
  assign lenOk     = (cfg_nbits_i != '0) && (cfg_nbits_i <= NW'(CHAIN_LEN));
  assign wrAllowed = wr_en_i && !busy_q;
  assign captureEn = (state_q == CLK_HI) && tick && !abort_i;
  assign capWord   = AW'(idx_q / NW'(WORD_W));
  assign capBit    = BW'(idx_q % NW'(WORD_W));
  // A write landing in the start cycle must already be visible as the first shifted bit.
  assign txBit0    = (wrAllowed && wr_addr_i == '0) ? wr_data_i[0] : txMem[0][0];

  always_ff @(posedge fw_clk_i) begin
    if (wrAllowed) txMem[wr_addr_i] <= wr_data_i;
    if (captureEn) rxMem[capWord][capBit] <= fw_config_out_i;
  end

  always_ff @(posedge fw_clk_i or posedge fw_rst_i) begin
    if (fw_rst_i) rdData_q <= '0;
    else          rdData_q <= rxMem[rd_addr_i];
  end

`ifdef CMS_PIX_28_FW_CFG_SHIFTER_CMP_EN
  logic cmpAcc_q;
  logic cmpMis_q;
  assign cmp_mismatch_o = cmpMis_q;
`endif

  always_ff @(posedge fw_clk_i or posedge fw_rst_i) begin
    if (fw_rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      halfDiv_q <= '0;
      idx_q     <= '0;
      nbits_q   <= '0;
      tail_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      errLen_q  <= 1'b0;
      cfgClk_q  <= 1'b0;
      cfgIn_q   <= 1'b0;
      cfgLoad_q <= 1'b0;
`ifdef CMS_PIX_28_FW_CFG_SHIFTER_CMP_EN
      cmpAcc_q  <= 1'b0;
      cmpMis_q  <= 1'b0;
`endif
    end else if (abort_i && state_q != IDLE) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      tail_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfgClk_q  <= 1'b0;
      cfgIn_q   <= 1'b0;
      cfgLoad_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= tick ? '0 : cnt_q + DIV_W'(1);
      unique case (state_q)
        IDLE: begin
          if (start_i && !abort_i) begin
            if (lenOk) begin
              state_q   <= SETUP;
              nbits_q   <= cfg_nbits_i;
              halfDiv_q <= cfg_half_div_i;
              cnt_q     <= '0;
              idx_q     <= '0;
              tail_q    <= 1'b0;
              busy_q    <= 1'b1;
              errLen_q  <= 1'b0;
              cfgIn_q   <= txBit0;
`ifdef CMS_PIX_28_FW_CFG_SHIFTER_CMP_EN
              cmpAcc_q  <= 1'b0;
              cmpMis_q  <= 1'b0;
`endif
            end else begin
              errLen_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (tick) begin
            state_q  <= CLK_HI;
            cfgClk_q <= 1'b1;
          end
        end
        CLK_HI: begin
          if (tick) begin
            state_q  <= CLK_LO;
            cfgClk_q <= 1'b0;
`ifdef CMS_PIX_28_FW_CFG_SHIFTER_CMP_EN
            cmpAcc_q <= cmpAcc_q | (fw_config_out_i ^ txBitAt(idx_q));
`endif
            // On the last bit the index holds and the low phase becomes the tail.
            if (idx_q == nbits_q - NW'(1)) begin
              tail_q <= 1'b1;
            end else begin
              idx_q   <= idx_q + NW'(1);
              cfgIn_q <= txBitAt(idx_q + NW'(1));
            end
          end
        end
        CLK_LO: begin
          if (tick) begin
            if (tail_q) begin
              state_q   <= LOAD;
              cfgLoad_q <= 1'b1;
              cfgIn_q   <= 1'b0;
            end else begin
              state_q  <= CLK_HI;
              cfgClk_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (tick) begin
            state_q   <= DONE;
            cfgLoad_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
`ifdef CMS_PIX_28_FW_CFG_SHIFTER_CMP_EN
            cmpMis_q  <= cmpAcc_q;
`endif
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef CMS_PIX_28_FW_CFG_SHIFTER_CMP_EN
  assign cmp_mismatch_o = 1'b0;
`endif

  assign rd_data_o        = rdData_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_len_o        = errLen_q;
  assign fw_config_clk_o  = cfgClk_q;
  assign fw_config_in_o   = cfgIn_q;
  assign fw_config_load_o = cfgLoad_q;

endmodule

// File: tb/tb_cms_pix_28_fw_cfg_shifter.sv
// Testbench for cms_pix_28_fw_cfg_shifter: a behavioural DUT chain on the config pins plus a
// bit-level model of the TX/RX buffers predicts pin activity, RX contents and write-verify.
module tb_cms_pix_28_fw_cfg_shifter;

  localparam int CHAIN_LEN = 256;
  localparam int WORD_W    = 32;
  localparam int DIV_W     = 8;
  localparam int NUM_WORDS = CHAIN_LEN / WORD_W;
  localparam int AW        = 3;
  localparam int NW        = 9;
`ifdef CMS_PIX_28_FW_CFG_SHIFTER_CMP_EN
  localparam bit CMP_ON = 1'b1;
`else
  localparam bit CMP_ON = 1'b0;
`endif

  logic              fwClk = 1'b0;
  logic              fwRst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [NW-1:0]     cfgNbits = '0;
  logic [DIV_W-1:0]  cfgHalfDiv = '0;
  logic              wrEn = 1'b0;
  logic [AW-1:0]     wrAddr = '0;
  logic [WORD_W-1:0] wrData = '0;
  logic [AW-1:0]     rdAddr = '0;
  logic [WORD_W-1:0] rdData;
  logic              busy, done, errLen, cmpMis, cfgClk, cfgIn, cfgLoad;
  logic              dutOut = 1'b0;

  cms_pix_28_fw_cfg_shifter #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .DIV_W(DIV_W)) dut (
    .fw_clk_i(fwClk), .fw_rst_i(fwRst), .start_i(start), .abort_i(abort),
    .cfg_nbits_i(cfgNbits), .cfg_half_div_i(cfgHalfDiv),
    .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_data_i(wrData),
    .rd_addr_i(rdAddr), .rd_data_o(rdData),
    .busy_o(busy), .done_o(done), .err_len_o(errLen), .cmp_mismatch_o(cmpMis),
    .fw_config_clk_o(cfgClk), .fw_config_in_o(cfgIn), .fw_config_load_o(cfgLoad),
    .fw_config_out_i(dutOut)
  );

  always #5 fwClk = ~fwClk;

  int checks = 0;
  int errors = 0;

  // Reference buffers: TX as written, RX as predicted, with a mask of RX bits known so far.
  logic [WORD_W-1:0] txModel [NUM_WORDS];
  logic [WORD_W-1:0] rxModel [NUM_WORDS];
  logic [WORD_W-1:0] rxMask  [NUM_WORDS];

  // Behavioural DUT chain: samples config_in on the rising shift clock, shifts on the falling one.
  bit chainQ[$] = '{1'b0, 1'b0, 1'b0, 1'b0};
  bit latchedIn = 1'b0;

  int   busyCycles, doneCount, loadCycles, hiCycles, rises;
  logic inSeq [CHAIN_LEN];

  // Per-cycle pin activity, sampled mid-cycle away from the active edge.
  always @(negedge fwClk) begin
    if (busy === 1'b1)    busyCycles++;
    if (done === 1'b1)    doneCount++;
    if (cfgLoad === 1'b1) loadCycles++;
    if (cfgClk === 1'b1)  hiCycles++;
  end

  // Record the serial data seen by the chain on each rising shift clock.
  always @(posedge cfgClk) begin
    if (rises < CHAIN_LEN) inSeq[rises] = cfgIn;
    rises++;
    latchedIn = cfgIn;
  end

  // The chain advances on the falling shift clock and presents its next bit.
  always @(negedge cfgClk) begin
    if (chainQ.size() > 0) begin
      chainQ.push_back(latchedIn);
      void'(chainQ.pop_front());
      dutOut = chainQ[0];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge fwClk);
    #1;
  endtask

  task automatic clearMonitors();
    busyCycles = 0; doneCount = 0; loadCycles = 0; hiCycles = 0; rises = 0;
    for (int i = 0; i < CHAIN_LEN; i++) inSeq[i] = 1'b0;
  endtask

  task automatic applyStimulus(input int nbits, input int hdiv, input bit withAbort);
    cfgNbits   = NW'(nbits);
    cfgHalfDiv = DIV_W'(hdiv);
    start      = 1'b1;
    abort      = withAbort;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic writeTx(input int addr, input logic [WORD_W-1:0] data);
    wrEn = 1'b1; wrAddr = AW'(addr); wrData = data;
    tick();
    wrEn = 1'b0;
    txModel[addr] = data;
  endtask

  task automatic readRx(input int w, output logic [WORD_W-1:0] data);
    rdAddr = AW'(w);
    tick();
    data = rdData;
  endtask

  task automatic setChain(input int len, input logic [63:0] pattern, input bit useRandom);
    chainQ.delete();
    for (int i = 0; i < len; i++) chainQ.push_back(useRandom ? bit'($urandom_range(0, 1)) : pattern[i]);
    dutOut = chainQ[0];
  endtask

  function automatic bit txBit(input int k);
    return txModel[k / WORD_W][k % WORD_W];
  endfunction

  // Full shift with prediction: captured bit k is the chain's original bit k while it lasts,
  // then the TX bits that were fed in behind it.
  task automatic runShift(input int nbits, input int hdiv);
    int                hh;
    int                budget;
    bit                snap[$];
    bit                expBit;
    bit                expMis;
    logic [WORD_W-1:0] obsWord;
    logic [WORD_W-1:0] maskWord;
    hh   = hdiv + 1;
    snap = chainQ;
    clearMonitors();
    applyStimulus(nbits, hdiv, 1'b0);
    wrEn   = 1'b0;
    budget = hh * (2 * nbits + 2) + 16;
    for (int i = 0; i < budget && doneCount == 0; i++) tick();
    tick();
    tick();
    expMis = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      expBit = (k < snap.size()) ? snap[k] : txBit(k - snap.size());
      rxModel[k / WORD_W][k % WORD_W] = expBit;
      rxMask[k / WORD_W][k % WORD_W]  = 1'b1;
      if (expBit != txBit(k)) expMis = 1'b1;
    end
    checkOutput("doneCount", doneCount, 1);
    checkOutput("busyCycles", busyCycles, hh * (2 * nbits + 2));
    checkOutput("clkRises", rises, nbits);
    checkOutput("clkHiCycles", hiCycles, nbits * hh);
    checkOutput("loadCycles", loadCycles, hh);
    checkOutput("errLen", errLen, 0);
    checkOutput("cmpMismatch", cmpMis, expMis & CMP_ON);
    for (int w = 0; w * WORD_W < nbits; w++) begin
      obsWord  = '0;
      maskWord = '0;
      for (int b = 0; b < WORD_W; b++) begin
        if (w * WORD_W + b < nbits) begin
          obsWord[b]  = inSeq[w * WORD_W + b];
          maskWord[b] = 1'b1;
        end
      end
      checkOutput("txSequence", obsWord, txModel[w] & maskWord);
      readRx(w, obsWord);
      checkOutput("rxWord", obsWord & rxMask[w], rxModel[w] & rxMask[w]);
    end
  endtask

  initial begin
    logic [WORD_W-1:0] word;
    bit                snap[$];
    int                nb;
    for (int w = 0; w < NUM_WORDS; w++) begin
      txModel[w] = '0; rxModel[w] = '0; rxMask[w] = '0;
    end

    // Reset state while reset is held.
    tick();
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstErrLen", errLen, 0);
    checkOutput("rstCmp", cmpMis, 0);
    checkOutput("rstPins", {cfgClk, cfgIn, cfgLoad}, 0);
    checkOutput("rstRdData", rdData, 0);
    fwRst = 1'b0;
    tick();

    // Basic 4-bit loop-back through a chain preloaded with 0x5.
    writeTx(0, 32'h0000_000B);
    setChain(4, 64'h5, 1'b0);
    runShift(4, 0);
    readRx(0, word);
    checkOutput("basicRx", word[3:0], 4'h5);

    // Divider: H = 4 cycles per phase.
    runShift(2, 3);

    // Length errors, then a legal start clears the flag.
    clearMonitors();
    applyStimulus(0, 0, 1'b0);
    repeat (3) tick();
    checkOutput("errLenZero", errLen, 1);
    checkOutput("errZeroBusy", busyCycles, 0);
    checkOutput("errZeroDone", doneCount, 0);
    applyStimulus(CHAIN_LEN + 1, 0, 1'b0);
    repeat (3) tick();
    checkOutput("errLenOver", errLen, 1);
    checkOutput("errOverBusy", busyCycles, 0);
    runShift(8, 0);

    // Asynchronous reset in the middle of a high shift-clock phase.
    setChain(8, 64'hC3, 1'b0);
    clearMonitors();
    applyStimulus(8, 2, 1'b0);
    for (int i = 0; i < 200 && rises < 2; i++) tick();
    checkOutput("rstMidReach", cfgClk, 1);
    #2 fwRst = 1'b1;
    #1;
    checkOutput("rstMidBusy", busy, 0);
    checkOutput("rstMidPins", {cfgClk, cfgIn, cfgLoad}, 0);
    tick();
    fwRst = 1'b0;
    tick();
    runShift(8, 1);

    // Abort during bit 5 of 16, with a write attempted while busy.
    setChain(16, 64'h0, 1'b1);
    snap = chainQ;
    clearMonitors();
    applyStimulus(16, 1, 1'b0);
    for (int i = 0; i < 200 && rises < 6; i++) tick();
    checkOutput("abortReach", rises, 6);
    wrEn = 1'b1; wrAddr = '0; wrData = ~txModel[0];
    tick();
    wrEn  = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortPins", {cfgClk, cfgIn, cfgLoad}, 0);
    repeat (4) tick();
    checkOutput("abortDone", doneCount, 0);
    checkOutput("abortLoad", loadCycles, 0);
    for (int k = 0; k < 5; k++) begin
      rxModel[0][k] = snap[k];
      rxMask[0][k]  = 1'b1;
    end
    readRx(0, word);
    checkOutput("abortRx", word & rxMask[0], rxModel[0] & rxMask[0]);
    runShift(16, 0);

    // Abort and start together in IDLE: nothing starts.
    clearMonitors();
    applyStimulus(8, 0, 1'b1);
    repeat (3) tick();
    checkOutput("abortStartBusy", busyCycles, 0);
    checkOutput("abortStartRises", rises, 0);

    // Write-verify: a zeroed 32-bit chain first, then the pattern it now holds.
    writeTx(0, 32'hA5A5_A5A5);
    setChain(32, 64'h0, 1'b0);
    runShift(32, 0);
    checkOutput("cmpFirst", cmpMis, CMP_ON);
    runShift(32, 0);
    checkOutput("cmpSecond", cmpMis, 0);

    // Boundaries: full chain length and the largest divider.
    for (int w = 0; w < NUM_WORDS; w++) writeTx(w, $urandom);
    setChain(40, 64'h0, 1'b1);
    runShift(CHAIN_LEN, 0);
    setChain(3, 64'h0, 1'b1);
    runShift(1, 255);

    // Randomized runs; the first one writes word 0 in the same cycle as start.
    for (int iter = 0; iter < 6; iter++) begin
      for (int w = 0; w < NUM_WORDS; w++) writeTx(w, $urandom);
      setChain($urandom_range(1, 64), 64'h0, 1'b1);
      nb = $urandom_range(1, CHAIN_LEN);
      if (iter == 0) begin
        wrEn = 1'b1; wrAddr = '0; wrData = $urandom;
        txModel[0] = wrData;
      end
      runShift(nb, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
